filter_mixer: RTL and testbench
===============================

Name: filter_mixer

Overview:
- Output stage directly downstream of the SID state-variable filter.
- Once per audio tick it snapshots the filter's LP/BP/HP outputs and the unfiltered voice sum, then adds the modes enabled in register $18 to the direct path.
- It then applies the 4-bit master volume, shifts and saturates, and presents one signed sample to the DAC/PWM stage with a valid pulse.
- It is time-multiplexed: a small FSM, one accumulator and one multiply.

Parameters:
- OUT_W, 16: output sample width, signed.
- SHIFT, 4: arithmetic right shift applied after the volume multiply.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clkEn  in  1  audio tick, the same strobe that drives the filter
- iLP  in  32  signed filter lowpass output
- iBP  in  32  signed filter bandpass output
- iHP  in  32  signed filter highpass output
- iDirect  in  32  signed sum of voices not routed to the filter
- iWE  in  1  register write strobe
- iAddr  in  5  register address
- iData  in  8  register write data
- oSample  out  OUT_W  signed mixed output sample
- oValid  out  1  one-cycle pulse, high when oSample has just updated
- oOverrun  out  1  sticky flag: clkEn arrived while busy

Behaviour:
- Reset, asynchronous, while rst=1:
  - oSample=0, oValid=0, oOverrun=0.
  - regModeVol=0, all snapshots and the accumulator cleared, state=IDLE.
  - Deassertion takes effect at the next clk edge.
- Register decode:
  - An iWE edge with iAddr=='h18 loads regModeVol<=iData.
  - Field layout: [3:0]=volume, [4]=LP enable, [5]=BP enable, [6]=HP enable, [7]=voice-3-off (stored only, unused here).
  - Other addresses are ignored.
- FSM states: IDLE, ACC0, ACC1, ACC2, ACC3, MUL, OUT.
- IDLE, edge with clkEn=1 (call it E0):
  - Capture iLP, iBP, iHP, iDirect and regModeVol (volume plus enables) into snapshot registers.
  - acc<=0, go to ACC0.
  - The snapshot holds the filter's previous-tick results, so all three modes are sample-aligned.
  - A register write on E0 itself is not captured: the old value is used and the new one applies next tick.
- ACC0..ACC3, edges E1..E4:
  - acc += direct, then LP if enabled, then BP if enabled, then HP if enabled; a disabled term adds 0.
  - acc is signed 34 bits (four 32-bit terms), so it never wraps.
- MUL, edge E5:
  - prod <= acc * {1'b0, vol}.
  - prod is signed 39 bits; volume is unsigned 0..15.
- OUT, edge E6:
  - oSample <= sat(prod >>> SHIFT) to OUT_W.
  - The shift floors toward negative infinity.
  - Values above 2^(OUT_W-1)-1 clamp to the max; values below -2^(OUT_W-1) clamp to the min.
  - oValid<=1, state<=IDLE.
- oValid is high for exactly the one cycle after E6 and returns to 0 at E7.
- Latency is fixed: clkEn sampled at E0 gives a new oSample at E6.
- Minimum clkEn spacing is 7 cycles.
- oSample holds its value between updates.
- clkEn=1 in any non-IDLE state is ignored: no restart, no snapshot, and oOverrun<=1 (sticky until rst).
- clkEn=1 in OUT: ignored and oOverrun set. The next tick is accepted only from IDLE.
- Register writes during a busy sample go to regModeVol only and never alter the sample in flight.
- Volume 0 gives oSample=0 regardless of inputs.
- rst asserted mid-sample aborts it: no oValid is produced for that tick.

Decomposition:
- Shared package/include sid_pkg:
  - register address constant ADDR_MODE_VOL='h18
  - field bit positions (VOL_LSB/MSB, LP_EN, BP_EN, HP_EN, V3_OFF)
  - FSM state encoding constants
  - accumulator and product widths (ACC_W=34, PROD_W=39)
- One sub-module, sat_shift: combinational arithmetic right shift by SHIFT plus saturation from PROD_W down to OUT_W.
  - Reusable by other output paths.
  - Instantiated once, feeding the OUT register.

Test Plan:
- Reset: hold rst, toggle clkEn -> oSample=0, oValid never rises, oOverrun=0. Release rst, wait 20 cycles with no clkEn -> still 0.
- LP only: write 'h18=0x1F; iLP=1000, iDirect=200, iBP=iHP=5000; one clkEn -> at E6 oSample=(1200*15)>>4=1125, oValid high exactly one cycle.
- All modes, signed: write 'h18=0x7F; direct=0, LP=100, BP=200, HP=300 -> 562. Negate all inputs -> -563, which confirms floor shifting.
- Saturation, with 'h18=0x7F:
  - iDirect=0x10000000 -> 32767.
  - iDirect=-0x10000000 -> -32768.
  - All four inputs 0x7FFFFFFF -> 32767, with no wrap.
- Busy and writes: clkEn at E0 and again at E3 -> single oValid at E6, oOverrun=1. Write 'h18=0x10 at E2 while old value 0x1F -> that sample still uses volume 15; the next tick uses volume 0 -> oSample=0.
- Reset mid-operation: assert rst at E3 -> oSample=0 immediately, no oValid at E6. After release, the next clkEn -> normal result at +6 with mode/volume at the reset value 0 -> oSample=0.

Source files
------------

// File: rtl/sid_pkg.sv
// sid_pkg: shared SID output-stage constants (mode/volume register, FSM encoding, datapath widths)
package sid_pkg;
  localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
  localparam int VOL_LSB = 0;
  localparam int VOL_MSB = 3;
  localparam int LP_EN   = 4;
  localparam int BP_EN   = 5;
  localparam int HP_EN   = 6;
  localparam int V3_OFF  = 7;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC0 = 3'd1;
  localparam logic [2:0] S_ACC1 = 3'd2;
  localparam logic [2:0] S_ACC2 = 3'd3;
  localparam logic [2:0] S_ACC3 = 3'd4;
  localparam logic [2:0] S_MUL  = 3'd5;
  localparam logic [2:0] S_OUT  = 3'd6;
  localparam int ACC_W  = 34;
  localparam int PROD_W = 39;
endpackage

// File: rtl/filter_mixer_sat_shift.sv
// sat_shift: floor arithmetic right shift by SHIFT, then saturate IN_W -> OUT_W; ports i_val (signed IN_W), o_val (signed OUT_W)
module sat_shift #(
  parameter int IN_W  = 39,
  parameter int OUT_W = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val
);
  logic signed [IN_W-1:0] w_sh;
  logic [IN_W-OUT_W:0] w_hi;
  logic w_fits;
  always_comb begin
    w_sh   = i_val >>> SHIFT;
    w_hi   = w_sh[IN_W-1:OUT_W-1];
    w_fits = (&w_hi) | ~(|w_hi);
    o_val  = w_fits ? w_sh[OUT_W-1:0] : w_sh[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/filter_mixer.sv
// filter_mixer: per-tick mix of direct path with enabled LP/BP/HP, master volume, shift and saturate; ports clk, rst, clkEn, iLP/iBP/iHP/iDirect, iWE/iAddr/iData in; oSample, oValid, oOverrun out
module filter_mixer
  import sid_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clkEn,
  input  logic signed [31:0]      iLP,
  input  logic signed [31:0]      iBP,
  input  logic signed [31:0]      iHP,
  input  logic signed [31:0]      iDirect,
  input  logic                    iWE,
  input  logic [4:0]              iAddr,
  input  logic [7:0]              iData,
  output logic signed [OUT_W-1:0] oSample,
  output logic                    oValid,
  output logic                    oOverrun
);
  logic [2:0] r_state;
  logic [7:0] r_mode;
  logic [6:0] r_snap;
  logic signed [31:0] r_lp, r_bp, r_hp, r_dir;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [OUT_W-1:0] r_sample;
  logic r_valid, r_ovr;
  logic signed [31:0] w_term;
  logic signed [ACC_W-1:0] w_term_x;
  logic signed [PROD_W-1:0] w_acc_x, w_vol_x, w_sat_in;
  logic signed [OUT_W-1:0] w_sat;
  logic w_unused_v3;
  assign w_unused_v3 = r_mode[V3_OFF];
  always_comb begin
    w_term = '0;
    w_term = r_state == S_ACC0 ? r_dir :
             (r_state == S_ACC1 && r_snap[LP_EN]) ? r_lp :
             (r_state == S_ACC2 && r_snap[BP_EN]) ? r_bp :
             (r_state == S_ACC3 && r_snap[HP_EN]) ? r_hp : '0;
    w_term_x = {{(ACC_W-32){w_term[31]}}, w_term};
    w_acc_x  = {{(PROD_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_vol_x  = {{(PROD_W-4){1'b0}}, r_snap[VOL_MSB:VOL_LSB]};
    w_sat_in = r_prod;
  end
  sat_shift #(.IN_W(PROD_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat (
    .i_val(w_sat_in),
    .o_val(w_sat)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= '0;
      r_snap   <= '0;
      r_lp     <= '0;
      r_bp     <= '0;
      r_hp     <= '0;
      r_dir    <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (iWE && iAddr == ADDR_MODE_VOL) r_mode <= iData;
      if (clkEn && r_state != S_IDLE) r_ovr <= 1'b1;
      r_valid <= r_state == S_OUT;
      if (r_state == S_IDLE && clkEn) begin
        r_lp   <= iLP;
        r_bp   <= iBP;
        r_hp   <= iHP;
        r_dir  <= iDirect;
        r_snap <= r_mode[6:0];
        r_acc  <= '0;
      end
      if (r_state >= S_ACC0 && r_state <= S_ACC3) r_acc <= r_acc + w_term_x;
      if (r_state == S_MUL) r_prod <= w_acc_x * w_vol_x;
      if (r_state == S_OUT) r_sample <= w_sat;
      r_state <= r_state == S_IDLE ? (clkEn ? S_ACC0 : S_IDLE) : r_state == S_OUT ? S_IDLE : r_state + 3'd1;
    end
  end
  assign oSample  = r_sample;
  assign oValid   = r_valid;
  assign oOverrun = r_ovr;
endmodule

// File: tb/tb_filter_mixer.sv
// tb_filter_mixer: randomized self-checking bench for filter_mixer against an arithmetic mixing model
module tb_filter_mixer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkEn = 1'b0;
  logic signed [31:0] iLP = '0, iBP = '0, iHP = '0, iDirect = '0;
  logic iWE = 1'b0;
  logic [4:0] iAddr = '0;
  logic [7:0] iData = '0;
  logic signed [15:0] oSample;
  logic oValid, oOverrun;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_mode = 8'h00;
  logic m_ovr = 1'b0;
  filter_mixer #(.OUT_W(16), .SHIFT(4)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .iLP(iLP), .iBP(iBP), .iHP(iHP), .iDirect(iDirect),
    .iWE(iWE), .iAddr(iAddr), .iData(iData),
    .oSample(oSample), .oValid(oValid), .oOverrun(oOverrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint model(input logic signed [31:0] d, l, b, h, input logic [7:0] mode);
    longint s, v, q;
    s = d;
    if (mode[4]) s += l;
    if (mode[5]) s += b;
    if (mode[6]) s += h;
    v = mode[3:0];
    q = (s * v) >>> 4;
    return q > 32767 ? 32767 : q < -32768 ? -32768 : q;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_reg(input logic [4:0] a, input logic [7:0] d);
    iWE = 1'b1; iAddr = a; iData = d;
    step();
    iWE = 1'b0;
    if (a == 5'h18) m_mode = d;
  endtask
  task automatic run(input logic signed [31:0] d, l, b, h, input int wr_at, input logic [7:0] wd, input int en_at);
    longint e;
    e = model(d, l, b, h, m_mode);
    iDirect = d; iLP = l; iBP = b; iHP = h; clkEn = 1'b1;
    if (wr_at == 0) begin iWE = 1'b1; iAddr = 5'h18; iData = wd; end
    step();
    clkEn = 1'b0; iWE = 1'b0;
    if (wr_at == 0) m_mode = wd;
    iDirect = $urandom; iLP = $urandom; iBP = $urandom; iHP = $urandom;
    for (int k = 1; k <= 6; k++) begin
      if (k == wr_at) begin iWE = 1'b1; iAddr = 5'h18; iData = wd; end
      if (k == en_at) clkEn = 1'b1;
      step();
      iWE = 1'b0; clkEn = 1'b0;
      if (k == wr_at) m_mode = wd;
      if (k == en_at) m_ovr = 1'b1;
      chk("valid_timing", oValid, k == 6);
    end
    chk("sample", oSample, e);
    chk("overrun", oOverrun, m_ovr);
    step();
    chk("valid_drop", oValid, 0);
  endtask
  function automatic logic signed [31:0] rnd_val();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 32'($urandom) : r == 1 ? 32'($urandom_range(0, 4000)) - 32'sd2000 :
           r == 2 ? 32'($urandom_range(0, 2097152)) - 32'sd1048576 : 32'($urandom_range(0, 200000)) - 32'sd100000;
  endfunction
  initial begin
    #1;
    for (int i = 0; i < 6; i++) begin
      clkEn = ~clkEn;
      step();
      chk("rst_valid", oValid, 0);
    end
    clkEn = 1'b0;
    chk("rst_sample", oSample, 0);
    chk("rst_overrun", oOverrun, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_sample", oSample, 0);
    chk("idle_valid", oValid, 0);
    chk("idle_overrun", oOverrun, 0);
    wr_reg(5'h18, 8'h1F);
    run(200, 1000, 5000, 5000, -1, 8'h00, 0);
    chk("lp_only_const", oSample, 1125);
    wr_reg(5'h18, 8'h7F);
    run(0, 100, 200, 300, -1, 8'h00, 0);
    chk("all_modes_const", oSample, 562);
    run(0, -100, -200, -300, -1, 8'h00, 0);
    chk("floor_const", oSample, -563);
    run(32'h10000000, 0, 0, 0, -1, 8'h00, 0);
    chk("sat_max", oSample, 32767);
    run(-32'sh10000000, 0, 0, 0, -1, 8'h00, 0);
    chk("sat_min", oSample, -32768);
    run(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, -1, 8'h00, 0);
    chk("sat_nowrap", oSample, 32767);
    wr_reg(5'h03, 8'h00);
    run(0, 100, 200, 300, -1, 8'h00, 0);
    chk("other_addr_ignored", oSample, 562);
    wr_reg(5'h18, 8'h1F);
    run(200, 1000, 5000, 5000, 2, 8'h10, 3);
    chk("busy_old_vol", oSample, 1125);
    chk("busy_overrun", oOverrun, 1);
    run(200, 1000, 5000, 5000, -1, 8'h00, 0);
    chk("vol_zero", oSample, 0);
    wr_reg(5'h18, 8'h7F);
    run(0, 100, 200, 300, -1, 8'h00, 0);
    iDirect = 1000; iLP = 1000; iBP = 1000; iHP = 1000; clkEn = 1'b1;
    step();
    clkEn = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_sample", oSample, 0);
    chk("midrst_valid", oValid, 0);
    chk("midrst_overrun", oOverrun, 0);
    step();
    step();
    rst = 1'b0;
    m_mode = 8'h00;
    m_ovr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("aborted_no_valid", oValid, 0);
    end
    run(1234, 5678, -999, 42, -1, 8'h00, 0);
    chk("after_rst_vol0", oSample, 0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) wr_reg(5'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 0) wr_reg(5'h18, 8'($urandom));
      run(rnd_val(), rnd_val(), rnd_val(), rnd_val(), int'($urandom_range(0, 7)) - 1, 8'($urandom), int'($urandom_range(0, 6)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
